// File: rtl/seq_restoring_div_if.sv
// Start/done handshake and operand/result bundle for the sequential restoring divider.
// The controller side uses the master modport and the divider uses the slave modport.
interface seq_restoring_div_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// The dividend shift register doubles as the quotient register: each iteration
// shifts the next dividend bit out of the top and the new quotient bit in at the
// bottom, so after WIDTH iterations it holds the complete quotient.
// A zero divisor makes a single pass through CALC so that both the normal and the
// divide-by-zero results are committed by the same completion edge.
module seq_restoring_div #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    seq_restoring_div_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Captured operands and iteration state
    logic [WIDTH-1:0] shift_q;      // remaining dividend bits (top) / quotient bits (bottom)
    logic [WIDTH-1:0] divisor_q;
    logic             zero_q;       // captured divisor was zero
    logic [WIDTH:0]   rem_q;        // partial remainder, WIDTH+1 bits
    logic [CNT_W-1:0] cnt_q;

    // Committed results
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    // Restoring step signals
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic             last_iter;
    logic             accept;

    // FSM outputs
    logic             busy_o;
    logic             done_o;

    // A start is accepted in IDLE and in DONE (back-to-back operation)
    assign accept    = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_iter = zero_q || (cnt_q == CNT_W'(WIDTH - 1));

    // One restoring iteration: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], shift_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, divisor_q});
        rem_next  = q_bit ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = accept ? S_CALC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: busy while iterating, done for the single cycle in DONE
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_CALC:  busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // Operand capture and per-cycle iteration of the restoring algorithm
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            divisor_q <= '0;
            zero_q    <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            shift_q   <= bus.dividend;
            divisor_q <= bus.divisor;
            zero_q    <= (bus.divisor == '0);
            rem_q     <= '0;
            cnt_q     <= '0;
        end else if ((state_q == S_CALC) && !zero_q) begin
            shift_q   <= {shift_q[WIDTH-2:0], q_bit};
            rem_q     <= rem_next;
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers change only on the completion edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if ((state_q == S_CALC) && last_iter) begin
            if (zero_q) begin
                quotient_q  <= '1;
                remainder_q <= shift_q;
                dbz_q       <= 1'b1;
            end else begin
                quotient_q  <= {shift_q[WIDTH-2:0], q_bit};
                remainder_q <= rem_next[WIDTH-1:0];
                dbz_q       <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_o;
    assign bus.done        = done_o;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
